fetch_ctrl: RTL and testbench



---
 rtl/fetch_pkg.sv | 34 +++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: the halt
// marker, the sequencer states, the fault cause codes and the layout of
// one fetch buffer entry.
package fetch_pkg;

   localparam int INST_W = 32;

   // Fetching this word stops the sequencer until a redirect arrives
   localparam logic [INST_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_MISALIGN = 2'b01,
      CAUSE_RANGE    = 2'b10
   } fault_cause_t;

   // One buffered instruction together with the address it came from
   typedef struct packed {
      logic [INST_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   // Counter increment that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer holding fetched {pc, inst} entries between the
// fetch sequencer and decode. A flush empties the buffer but still lets a
// same-cycle pop complete, and a push into a full buffer is accepted when
// a pop frees the head slot in the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wr_entry,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;
   fetch_entry_t  store [DEPTH];

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && !flush && (!full || do_pop);

   // The head is forced to zero when empty so stale entries never leak out
   assign head = empty ? '0 : store[rd_ptr];

   // Pointer and occupancy bookkeeping; a flush realigns the write pointer
   // onto the (possibly advanced) read pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= rd_ptr + PW'(do_pop);
         wr_ptr <= rd_ptr + PW'(do_pop);
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + CW'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CW'(1);
         end
      end
   end

   // Entry storage needs no reset because the head is gated by empty
   always_ff @(posedge clk) begin
      if (do_push) begin
         store[wr_ptr] <= wr_entry;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Owns the fetch PC, reads one big-endian
// word per cycle from a combinational instruction memory, buffers it in
// fetch_fifo and offers it to decode through a valid/ready handshake.
// Redirects, halt words and misaligned/out-of-range fetches are handled
// here. Defining FETCH_PERF_EN adds saturating fetch/stall/flush counters.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int          MEM_BYTES  = 256,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        halt,
   output logic        fault,
   output logic [1:0]  fault_cause
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_flush
`endif
);

   // Highest PC from which a whole word still lies inside the memory
   localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

   fetch_state_t state_q;
   fetch_state_t state_d;
   fault_cause_t cause_q;
   fault_cause_t cause_d;
   logic [31:0]  fpc_q;
   logic [31:0]  fpc_d;
   logic         push;
   logic         pop;
   logic         flush;
   logic         misaligned;
   logic         out_of_range;
   logic         is_halt;
   logic         fifo_full;
   logic         fifo_empty;
   fetch_entry_t head;
   fetch_entry_t new_entry;

   assign imem_addr    = fpc_q;
   assign misaligned   = (fpc_q[1:0] != 2'b00);
   assign out_of_range = (fpc_q > LAST_PC);
   assign is_halt      = (imem_data == HALT_WORD);
   assign pop          = inst_valid && inst_ready;
   assign new_entry    = '{pc: fpc_q, inst: imem_data};

   assign inst_valid  = !fifo_empty;
   assign inst_data   = head.inst;
   assign inst_pc     = head.pc;
   assign halt        = (state_q == ST_HALT) && fifo_empty;
   assign fault       = (state_q == ST_FAULT) && fifo_empty;
   assign fault_cause = cause_q;

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .wr_entry(new_entry),
      .head    (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Sequencer state, fetch PC and latched fault cause
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         fpc_q   <= RESET_PC;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         cause_q <= cause_d;
      end
   end

   // Redirect beats everything; otherwise RUN checks alignment, range and
   // the halt marker before pushing the word and advancing the PC
   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      cause_d = cause_q;
      push    = 1'b0;
      flush   = 1'b0;
      if (redirect_valid) begin
         state_d = ST_RUN;
         fpc_d   = redirect_pc;
         cause_d = CAUSE_NONE;
         flush   = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (misaligned) begin
                  state_d = ST_FAULT;
                  cause_d = CAUSE_MISALIGN;
               end else if (out_of_range) begin
                  state_d = ST_FAULT;
                  cause_d = CAUSE_RANGE;
               end else if (is_halt) begin
                  state_d = ST_HALT;
               end else if (!fifo_full || pop) begin
                  push  = 1'b1;
                  fpc_d = fpc_q + 32'd4;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic stall_evt;

   assign stall_evt = (state_q == ST_RUN) && !redirect_valid && !misaligned &&
                      !out_of_range && !is_halt && fifo_full && !pop;

   // Saturating event counters for pushes, back-pressure stalls and flushes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
         perf_flush   <= '0;
      end else begin
         if (push) begin
            perf_fetched <= sat_inc(perf_fetched);
         end
         if (stall_evt) begin
            perf_stall <= sat_inc(perf_stall);
         end
         if (redirect_valid) begin
            perf_flush <= sat_inc(perf_flush);
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl. A byte-array memory model feeds the
// DUT; each scenario task queues the {pc, inst} pairs decode should see
// and retires them as handshakes occur.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        inst_ready = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        halt;
   logic        fault;
   logic [1:0]  fault_cause;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
   logic [31:0] perf_flush;
`endif

   logic [7:0]  mem [0:255];
   logic [63:0] exp_q [$];
   logic [63:0] exp_e;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // Big-endian combinational read; anything past the last word reads zero
   assign imem_data = (imem_addr <= 32'd252) ?
      {mem[imem_addr[7:0]], mem[imem_addr[7:0] + 8'd1],
       mem[imem_addr[7:0] + 8'd2], mem[imem_addr[7:0] + 8'd3]} : 32'h0;

   fetch_ctrl #(
      .MEM_BYTES (256),
      .RESET_PC  (32'h0000_0000),
      .FIFO_DEPTH(2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .inst_valid    (inst_valid),
      .inst_data     (inst_data),
      .inst_pc       (inst_pc),
      .inst_ready    (inst_ready),
      .halt          (halt),
      .fault         (fault),
      .fault_cause   (fault_cause)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_stall    (perf_stall),
      .perf_flush    (perf_flush)
`endif
   );

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic load_word(input int addr, input logic [31:0] w);
      mem[addr]     = w[31:24];
      mem[addr + 1] = w[23:16];
      mem[addr + 2] = w[15:8];
      mem[addr + 3] = w[7:0];
   endtask

   // Returns on the falling edge where reset was just released
   task automatic do_reset(input logic rdy);
      @(negedge clk);
      rst = 1'b1;
      redirect_valid = 1'b0;
      inst_ready = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      inst_ready = rdy;
   endtask

   task automatic test_reset();
      clear_mem();
      load_word(0, 32'h2008_0005);
      @(negedge clk);
      rst = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0080;
      repeat (2) @(negedge clk);
      checks++;
      if (imem_addr !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_addr got %h want %h", imem_addr, 32'h0);
      end
      checks++;
      if (inst_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_valid got %b want 0", inst_valid);
      end
      checks++;
      if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_head got %h/%h want 0/0", inst_pc, inst_data);
      end
      checks++;
      if (halt !== 1'b0 || fault !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags got halt=%b fault=%b want 0/0", halt, fault);
      end
      checks++;
      if (fault_cause !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_cause got %b want 00", fault_cause);
      end
      redirect_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (imem_addr !== 32'h4) begin
         errors++;
         $display("[TB] FAIL reset_redirect_ignored got %h want %h", imem_addr, 32'h4);
      end
   endtask

   task automatic test_halt_seq();
      clear_mem();
      load_word(0, 32'h2008_0005);
      load_word(4, 32'h2109_0001);
      load_word(8, 32'hFFFF_FFFF);
      do_reset(1'b1);
      exp_q.push_back({32'h0, 32'h2008_0005});
      exp_q.push_back({32'h4, 32'h2109_0001});
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
               errors++;
               $display("[TB] FAIL halt_first got v=%b pc=%h want 1/0", inst_valid, inst_pc);
            end
         end
         if (k == 2) begin
            checks++;
            if (inst_pc !== 32'h4) begin
               errors++;
               $display("[TB] FAIL halt_second got %h want 4", inst_pc);
            end
         end
         if (k == 3 || k == 8) begin
            checks++;
            if (halt !== 1'b1 || imem_addr !== 32'h8) begin
               errors++;
               $display("[TB] FAIL halt_state got halt=%b addr=%h want 1/8", halt, imem_addr);
            end
         end
         if (inst_valid && inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL halt_seq extra got pc=%h want none", inst_pc);
            end else begin
               exp_e = exp_q.pop_front();
               if ({inst_pc, inst_data} !== exp_e) begin
                  errors++;
                  $display("[TB] FAIL halt_seq got %h/%h want %h/%h",
                           inst_pc, inst_data, exp_e[63:32], exp_e[31:0]);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL halt_seq_missing got %0d left want 0", exp_q.size());
      end
   endtask

   task automatic test_stall();
      clear_mem();
      load_word(0, 32'h1111_1111);
      load_word(4, 32'h2222_2222);
      load_word(8, 32'h3333_3333);
      load_word(12, 32'hFFFF_FFFF);
      do_reset(1'b0);
      exp_q.push_back({32'h0, 32'h1111_1111});
      exp_q.push_back({32'h4, 32'h2222_2222});
      exp_q.push_back({32'h8, 32'h3333_3333});
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 3 || k == 4) begin
            checks++;
            if (imem_addr !== 32'h8 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
               errors++;
               $display("[TB] FAIL stall_hold got addr=%h v=%b pc=%h want 8/1/0",
                        imem_addr, inst_valid, inst_pc);
            end
         end
         if (k == 4) inst_ready = 1'b1;
         if (inst_valid && inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL stall_seq extra got pc=%h want none", inst_pc);
            end else begin
               exp_e = exp_q.pop_front();
               if ({inst_pc, inst_data} !== exp_e) begin
                  errors++;
                  $display("[TB] FAIL stall_seq got %h/%h want %h/%h",
                           inst_pc, inst_data, exp_e[63:32], exp_e[31:0]);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0 || halt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stall_end got left=%0d halt=%b want 0/1", exp_q.size(), halt);
      end
   endtask

   task automatic test_redirect();
      clear_mem();
      load_word(0, 32'hA000_0000);
      load_word(4, 32'hA000_0004);
      load_word(8, 32'hA000_0008);
      load_word(12, 32'hA000_000C);
      load_word(32'h40, 32'hB000_0040);
      load_word(32'h44, 32'hB000_0044);
      load_word(32'h48, 32'hFFFF_FFFF);
      do_reset(1'b0);
      exp_q.push_back({32'h0, 32'hA000_0000});
      exp_q.push_back({32'h4, 32'hA000_0004});
      exp_q.push_back({32'h40, 32'hB000_0040});
      exp_q.push_back({32'h44, 32'hB000_0044});
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 2) inst_ready = 1'b1;
         if (k == 3) begin
            checks++;
            if (inst_pc !== 32'h4 || imem_addr !== 32'hC) begin
               errors++;
               $display("[TB] FAIL redir_setup got pc=%h addr=%h want 4/c", inst_pc, imem_addr);
            end
            redirect_valid = 1'b1;
            redirect_pc = 32'h40;
         end
         if (k == 4) begin
            redirect_valid = 1'b0;
            checks++;
            if (inst_valid !== 1'b0 || imem_addr !== 32'h40) begin
               errors++;
               $display("[TB] FAIL redir_flush got v=%b addr=%h want 0/40", inst_valid, imem_addr);
            end
         end
         if (k == 5) begin
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin
               errors++;
               $display("[TB] FAIL redir_target got v=%b pc=%h want 1/40", inst_valid, inst_pc);
            end
         end
         if (inst_valid && inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL redir_seq extra got pc=%h want none", inst_pc);
            end else begin
               exp_e = exp_q.pop_front();
               if ({inst_pc, inst_data} !== exp_e) begin
                  errors++;
                  $display("[TB] FAIL redir_seq got %h/%h want %h/%h",
                           inst_pc, inst_data, exp_e[63:32], exp_e[31:0]);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0 || halt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL redir_end got left=%0d halt=%b want 0/1", exp_q.size(), halt);
      end
   endtask

   task automatic test_fault();
      load_word(32'h10, 32'hC000_0010);
      load_word(32'h14, 32'hFFFF_FFFF);
      exp_q.push_back({32'h10, 32'hC000_0010});
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h42;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) redirect_valid = 1'b0;
         if (k == 3) begin
            checks++;
            if (fault !== 1'b1 || fault_cause !== 2'b01 || imem_addr !== 32'h42) begin
               errors++;
               $display("[TB] FAIL fault_misalign got f=%b c=%b addr=%h want 1/01/42",
                        fault, fault_cause, imem_addr);
            end
            checks++;
            if (inst_valid !== 1'b0 || halt !== 1'b0) begin
               errors++;
               $display("[TB] FAIL fault_quiet got v=%b halt=%b want 0/0", inst_valid, halt);
            end
            redirect_valid = 1'b1;
            redirect_pc = 32'h10;
         end
         if (k == 4) begin
            redirect_valid = 1'b0;
            checks++;
            if (fault !== 1'b0 || fault_cause !== 2'b00) begin
               errors++;
               $display("[TB] FAIL fault_clear got f=%b c=%b want 0/00", fault, fault_cause);
            end
         end
         if (inst_valid && inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL fault_seq extra got pc=%h want none", inst_pc);
            end else begin
               exp_e = exp_q.pop_front();
               if ({inst_pc, inst_data} !== exp_e) begin
                  errors++;
                  $display("[TB] FAIL fault_seq got %h/%h want %h/%h",
                           inst_pc, inst_data, exp_e[63:32], exp_e[31:0]);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0 || halt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fault_end got left=%0d halt=%b want 0/1", exp_q.size(), halt);
      end
   endtask

   task automatic test_range();
      clear_mem();
      load_word(32'hF8, 32'hD000_00F8);
      load_word(32'hFC, 32'hD000_00FC);
      do_reset(1'b1);
      redirect_valid = 1'b1;
      redirect_pc = 32'hF8;
      exp_q.push_back({32'hF8, 32'hD000_00F8});
      exp_q.push_back({32'hFC, 32'hD000_00FC});
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) redirect_valid = 1'b0;
         if (inst_valid && inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL range_seq extra got pc=%h want none", inst_pc);
            end else begin
               exp_e = exp_q.pop_front();
               if ({inst_pc, inst_data} !== exp_e) begin
                  errors++;
                  $display("[TB] FAIL range_seq got %h/%h want %h/%h",
                           inst_pc, inst_data, exp_e[63:32], exp_e[31:0]);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL range_missing got %0d left want 0", exp_q.size());
      end
      checks++;
      if (fault !== 1'b1 || fault_cause !== 2'b10 || imem_addr !== 32'h100) begin
         errors++;
         $display("[TB] FAIL range_fault got f=%b c=%b addr=%h want 1/10/100",
                  fault, fault_cause, imem_addr);
      end
   endtask

   task automatic test_async_reset();
      clear_mem();
      load_word(0, 32'h5555_0000);
      load_word(4, 32'h5555_0004);
      load_word(8, 32'h5555_0008);
      do_reset(1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || imem_addr !== 32'h8) begin
         errors++;
         $display("[TB] FAIL async_pre got v=%b addr=%h want 1/8", inst_valid, imem_addr);
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL async_head got v=%b pc=%h data=%h want 0/0/0",
                  inst_valid, inst_pc, inst_data);
      end
      checks++;
      if (imem_addr !== 32'h0 || halt !== 1'b0 || fault !== 1'b0 || fault_cause !== 2'b00) begin
         errors++;
         $display("[TB] FAIL async_state got addr=%h halt=%b f=%b c=%b want 0/0/0/00",
                  imem_addr, halt, fault, fault_cause);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_halt_seq();
      test_stall();
      test_redirect();
      test_fault();
      test_range();
      test_async_reset();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
